// File: rtl/compare_pkg.sv
// Shared opcode definitions for compare_tracker and its bus interface.
package compare_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_EQ    = 3'd0,
    OP_GT    = 3'd1,
    OP_LT    = 3'd2,
    OP_MAX   = 3'd3,
    OP_MIN   = 3'd4,
    OP_RMAX  = 3'd5,
    OP_RMIN  = 3'd6,
    OP_COUNT = 3'd7
  } op_e;

endpackage

// File: rtl/compare_tracker_if.sv
// Sample/result handshake bus for compare_tracker; master drives operands, slave returns results.
interface compare_tracker_if
  import compare_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int OUT_WIDTH = 2*WIDTH
);
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic [OP_W-1:0]      operation;
  logic                 inValid;
  logic                 inReady;
  logic                 clearStats;
  logic [OUT_WIDTH-1:0] returnValue;
  logic                 outValid;
  logic                 outReady;

  modport master (
    output x, y, operation, inValid, clearStats, outReady,
    input  inReady, returnValue, outValid
  );

  modport slave (
    input  x, y, operation, inValid, clearStats, outReady,
    output inReady, returnValue, outValid
  );
endinterface

// File: rtl/compare_core.sv
// Per-lane combinational compare: eq/gt/lt plus max/min of a[i] vs b[i].
// Signed two's-complement ordering when COMPARE_TRACKER_SIGNED_EN is defined.
module compare_core #(
  parameter int WIDTH     = 4,
  parameter int NUM_LANES = 1
) (
  input  logic [NUM_LANES-1:0][WIDTH-1:0] a,
  input  logic [NUM_LANES-1:0][WIDTH-1:0] b,
  output logic [NUM_LANES-1:0]            eq,
  output logic [NUM_LANES-1:0]            gt,
  output logic [NUM_LANES-1:0]            lt,
  output logic [NUM_LANES-1:0][WIDTH-1:0] max_o,
  output logic [NUM_LANES-1:0][WIDTH-1:0] min_o
);
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign eq[i] = (a[i] == b[i]);
`ifdef COMPARE_TRACKER_SIGNED_EN
    assign gt[i] = ($signed(a[i]) > $signed(b[i]));
    assign lt[i] = ($signed(a[i]) < $signed(b[i]));
`else
    assign gt[i] = (a[i] > b[i]);
    assign lt[i] = (a[i] < b[i]);
`endif
    assign max_o[i] = gt[i] ? a[i] : b[i];
    assign min_o[i] = lt[i] ? a[i] : b[i];
  end
endmodule

// File: rtl/compare_tracker.sv
// Compare/statistics unit with a one-deep registered result and valid/ready handshake.
// Optional COMPARE_TRACKER_SIGNED_EN: two's-complement operands and sign-extended results.
module compare_tracker
  import compare_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int OUT_WIDTH = 2*WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  compare_tracker_if.slave  bus
);
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0]     run_max_q, run_max_d;
  logic [WIDTH-1:0]     run_min_q, run_min_d;
  logic [OUT_WIDTH-1:0] count_q, count_d;
  logic                 empty_q, empty_d;

  logic                 accept;
  logic                 stat_empty;
  op_e                  op;
  logic [WIDTH-1:0]     new_max, new_min;
  logic [OUT_WIDTH-1:0] new_count;

  logic                          xy_eq, xy_gt, xy_lt;
  logic [WIDTH-1:0]              xy_max, xy_min;
  logic [1:0]                    st_eq, st_gt, st_lt;
  logic [1:0][WIDTH-1:0]         st_max, st_min;

  function automatic logic [OUT_WIDTH-1:0] ext(input logic [WIDTH-1:0] v);
`ifdef COMPARE_TRACKER_SIGNED_EN
    return {{(OUT_WIDTH-WIDTH){v[WIDTH-1]}}, v};
`else
    return {{(OUT_WIDTH-WIDTH){1'b0}}, v};
`endif
  endfunction

  compare_core #(.WIDTH(WIDTH), .NUM_LANES(1)) u_xy (
    .a(bus.x), .b(bus.y),
    .eq(xy_eq), .gt(xy_gt), .lt(xy_lt),
    .max_o(xy_max), .min_o(xy_min)
  );

  // Lane 0 folds the sample max into runMax, lane 1 folds the sample min into runMin.
  compare_core #(.WIDTH(WIDTH), .NUM_LANES(2)) u_stat (
    .a({run_min_q, run_max_q}), .b({xy_min, xy_max}),
    .eq(st_eq), .gt(st_gt), .lt(st_lt),
    .max_o(st_max), .min_o(st_min)
  );

  assign bus.inReady     = !out_valid_q || bus.outReady;
  assign bus.outValid    = out_valid_q;
  assign bus.returnValue = result_q;
  assign accept          = bus.inValid && bus.inReady;
  assign op              = op_e'(bus.operation);

  // A clear on the same cycle as an accept makes this sample the seed.
  assign stat_empty = empty_q || bus.clearStats;
  assign new_max    = stat_empty ? xy_max : st_max[0];
  assign new_min    = stat_empty ? xy_min : st_min[1];
  assign new_count  = stat_empty ? OUT_WIDTH'(1)
                    : (&count_q ? count_q : count_q + OUT_WIDTH'(1));

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    run_max_d   = run_max_q;
    run_min_d   = run_min_q;
    count_d     = count_q;
    empty_d     = empty_q;

    if (bus.clearStats) begin
      empty_d = 1'b1;
      count_d = '0;
    end

    if (accept) begin
      run_max_d   = new_max;
      run_min_d   = new_min;
      count_d     = new_count;
      empty_d     = 1'b0;
      out_valid_d = 1'b1;
      case (op)
        OP_EQ:    result_d = OUT_WIDTH'(xy_eq);
        OP_GT:    result_d = OUT_WIDTH'(xy_gt);
        OP_LT:    result_d = OUT_WIDTH'(xy_lt);
        OP_MAX:   result_d = ext(xy_max);
        OP_MIN:   result_d = ext(xy_min);
        OP_RMAX:  result_d = ext(new_max);
        OP_RMIN:  result_d = ext(new_min);
        OP_COUNT: result_d = new_count;
        default:  result_d = '0;
      endcase
    end else if (bus.outReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      run_max_q   <= '0;
      run_min_q   <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      run_max_q   <= run_max_d;
      run_min_q   <= run_min_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
    end
  end
endmodule

// File: tb/tb_compare_tracker.sv
// Self-checking bench for compare_tracker (WIDTH=4, OUT_WIDTH=8): vector table + scoreboard.
module tb_compare_tracker;
  import compare_pkg::*;

  localparam int W  = 4;
  localparam int OW = 8;
`ifdef COMPARE_TRACKER_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  compare_tracker_if #(.WIDTH(W), .OUT_WIDTH(OW)) bus ();

  compare_tracker #(.WIDTH(W), .OUT_WIDTH(OW)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [2:0]    op;
    logic          clr;
    logic [OW-1:0] exp_u;
    logic [OW-1:0] exp_s;
  } vec_t;

  vec_t          vecs[$];
  logic [OW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Results are consumed when the handshake completes at the upcoming edge.
  always @(negedge clock) begin
    if (!reset && bus.outValid === 1'b1 && bus.outReady === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%0h with no pending expectation", bus.returnValue);
      end else begin
        chk("scoreboard", bus.returnValue, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic clr, input logic [OW-1:0] exp);
    bit done = 0;
    bus.x = a; bus.y = b; bus.operation = op; bus.clearStats = clr; bus.inValid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      if (bus.inReady === 1'b1) begin
        exp_q.push_back(exp);
        done = 1;
      end
      @(posedge clock); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: inReady=%0b required 1", bus.inReady);
    end
    bus.inValid = 1'b0;
    bus.clearStats = 1'b0;
  endtask

  initial begin
    vecs = '{
      '{4'd5,  4'd5,  3'd0, 1'b0, 8'h01, 8'h01},
      '{4'd3,  4'd9,  3'd1, 1'b0, 8'h00, 8'h01},
      '{4'd3,  4'd9,  3'd2, 1'b0, 8'h01, 8'h00},
      '{4'd3,  4'd9,  3'd3, 1'b0, 8'h09, 8'h03},
      '{4'd3,  4'd9,  3'd4, 1'b0, 8'h03, 8'hF9},
      '{4'd3,  4'd9,  3'd7, 1'b0, 8'h06, 8'h06},
      '{4'd2,  4'd7,  3'd5, 1'b1, 8'h07, 8'h07},
      '{4'd12, 4'd1,  3'd5, 1'b0, 8'h0C, 8'h07},
      '{4'd4,  4'd4,  3'd5, 1'b0, 8'h0C, 8'h07},
      '{4'd4,  4'd4,  3'd6, 1'b0, 8'h01, 8'hFC},
      '{4'd4,  4'd4,  3'd7, 1'b0, 8'h05, 8'h05},
      '{4'd15, 4'd0,  3'd6, 1'b0, 8'h00, 8'hFC},
      '{4'd15, 4'd15, 3'd5, 1'b0, 8'h0F, 8'h07},
      '{4'd0,  4'd0,  3'd7, 1'b0, 8'h08, 8'h08},
      '{4'd8,  4'd3,  3'd3, 1'b0, 8'h08, 8'h03},
      '{4'd8,  4'd3,  3'd4, 1'b0, 8'h03, 8'hF8},
      '{4'd8,  4'd3,  3'd1, 1'b0, 8'h01, 8'h00}
    };

    reset = 1'b1;
    bus.x = '0; bus.y = '0; bus.operation = '0;
    bus.inValid = 1'b0; bus.clearStats = 1'b0; bus.outReady = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_outValid", {7'd0, bus.outValid}, 8'h00);
    chk("reset_returnValue", bus.returnValue, 8'h00);
    chk("reset_inReady", {7'd0, bus.inReady}, 8'h01);

    foreach (vecs[i])
      send(vecs[i].x, vecs[i].y, vecs[i].op, vecs[i].clr, SGN ? vecs[i].exp_s : vecs[i].exp_u);
    @(posedge clock); #1;

    // Backpressure: result held, inReady low, then drain and accept on one edge.
    bus.outReady = 1'b0;
    send(4'd6, 4'd2, 3'd3, 1'b0, 8'h06);
    bus.x = 4'd1; bus.y = 4'd7; bus.operation = 3'd4; bus.inValid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      chk("stall_inReady", {7'd0, bus.inReady}, 8'h00);
      chk("stall_hold", bus.returnValue, 8'h06);
    end
    bus.outReady = 1'b1;
    #1 chk("release_inReady", {7'd0, bus.inReady}, 8'h01);
    exp_q.push_back(8'h01);
    @(posedge clock); #1;
    bus.inValid = 1'b0;
    @(posedge clock); #1;

    // Clear without accept leaves the pending result alone.
    bus.outReady = 1'b0;
    send(4'd5, 4'd5, 3'd0, 1'b0, 8'h01);
    bus.clearStats = 1'b1;
    @(posedge clock); #1;
    bus.clearStats = 1'b0;
    chk("clear_keeps_valid", {7'd0, bus.outValid}, 8'h01);
    chk("clear_keeps_value", bus.returnValue, 8'h01);
    bus.outReady = 1'b1;
    send(4'd1, 4'd1, 3'd7, 1'b0, 8'h01);

    // Clear together with accept.
    send(4'd6, 4'd3, 3'd7, 1'b1, 8'h01);
    send(4'd9, 4'd9, 3'd6, 1'b0, SGN ? 8'hF9 : 8'h03);
    @(posedge clock); #1;

    // Reset discards an in-flight result.
    bus.outReady = 1'b0;
    send(4'd3, 4'd4, 3'd3, 1'b0, 8'h04);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    chk("rst_outValid", {7'd0, bus.outValid}, 8'h00);
    chk("rst_returnValue", bus.returnValue, 8'h00);
    bus.outReady = 1'b1;
    send(4'd2, 4'd2, 3'd7, 1'b0, 8'h01);

    // Count saturation.
    for (int k = 0; k < 260; k++)
      send(4'd1, 4'd1, 3'd7, (k == 0), (k + 1 > 255) ? 8'hFF : 8'(k + 1));

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clock);
    #1 chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/compare_tracker.md
COMPARE_TRACKER -- requirements
Module: compare_tracker

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits, legal range 2..16.
REQ-002 Parameter OUT_WIDTH, default 2*WIDTH: result width; SHALL be >= WIDTH+1.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 x  input  WIDTH  operand A.
REQ-006 y  input  WIDTH  operand B.
REQ-007 operation  input  3  opcode, sampled with the operands.
REQ-008 inValid  input  1  operands and opcode valid.
REQ-009 inReady  output  1  block can accept a sample this cycle.
REQ-010 clearStats  input  1  clears running statistics.
REQ-011 returnValue  output  OUT_WIDTH  registered result.
REQ-012 outValid  output  1  returnValue valid.
REQ-013 outReady  input  1  downstream accepts the result.

Function
REQ-014 Accept SHALL occur when inValid && inReady; inReady = !outValid || outReady, combinational.
REQ-015 Latency SHALL be exactly 1 cycle: a sample accepted at edge N drives returnValue/outValid after edge N.
REQ-016 Opcodes: 0 equal, 1 greater (x>y), 2 less (x<y), 3 max(x,y), 4 min(x,y), 5 running max, 6 running min, 7 sample count.
REQ-017 Boolean ops 0-2 SHALL zero-extend a 1-bit result to OUT_WIDTH; ops 3-6 SHALL zero-extend, or sign-extend when signed mode is enabled (REQ-029), a WIDTH result.
REQ-018 Every accept SHALL update runMax with max(runMax, x, y), runMin with min(runMin, x, y), and count with +1, regardless of opcode.
REQ-019 Ops 5-7 SHALL report the statistics including the sample just accepted.
REQ-020 count SHALL be OUT_WIDTH bits and saturate at 2^OUT_WIDTH-1; it SHALL not wrap.
REQ-021 After reset or clear, the first accepted sample SHALL seed runMax = max(x,y) and runMin = min(x,y); an internal "empty" flag SHALL track this.
REQ-022 clearStats without an accept SHALL set empty, count = 0 and SHALL leave outValid/returnValue unchanged.
REQ-023 clearStats together with an accept SHALL clear first; that sample becomes the first sample (count = 1).
REQ-024 With outValid=1 and outReady=0, returnValue SHALL hold stable and no sample SHALL be accepted.
REQ-025 With outValid=1, outReady=1 and no accept, outValid SHALL go to 0 on the next edge.
REQ-026 A reserved or unused opcode is not possible; all 8 values SHALL be decoded.

Reset
REQ-027 reset SHALL drive outValid=0, returnValue=0, count=0, runMax=0, runMin=0 and empty=1 on the next edge.
REQ-028 reset SHALL take priority over accept and clearStats; an in-flight result SHALL be discarded.

Configuration
REQ-029 With COMPARE_TRACKER_SIGNED_EN defined, x and y SHALL be two's-complement for ops 1-6 and results SHALL be sign-extended. Without it, all comparisons SHALL be unsigned and results zero-extended.

Structure
REQ-030 Package compare_pkg SHALL hold the opcode enumeration (OP_EQ..OP_COUNT) and the opcode width constant.
REQ-031 Sub-module compare_core (combinational; produces eq, gt, lt, max and min for WIDTH) SHALL be instantiated twice: once for x vs y, and once for the running statistics update.

Verification (WIDTH=4, OUT_WIDTH=8, unsigned unless noted)
REQ-032 Reset, then accept x=5, y=5, op=0 -> next cycle outValid=1, returnValue=0x01; then op=1 with 3,9 -> 0x00; then op=2 with 3,9 -> 0x01.
REQ-033 Accept the sequence (2,7), (12,1), (4,4) with op=5, then op=6 and op=7 -> results 0x07, 0x0C, 0x0C, then 0x01, then count 0x05.
REQ-034 Hold outReady=0 for 4 cycles with inValid=1 -> inReady=0 and returnValue stable; release -> the next sample is accepted on the same edge the result drains.
REQ-035 Assert clearStats simultaneously with accept of (6,3), op=7 -> 0x01; a following op=6 with (9,9) -> 0x03.
REQ-036 Signed build: x=4'b1000 (-8), y=4'b0011 (3), op=3 -> 0x03; op=4 -> 0xF8; op=1 -> 0x00.
REQ-037 Assert reset while outValid=1 and outReady=0 -> next cycle outValid=0, and op=7 on the next sample -> 0x01.
